// File: rtl/mux_scan_controller_pkg.sv
// Shared types and constants for the mux scan controller.
// Holds the FSM state encoding, the channel count and the select/word types.
// No ports; imported by the interface, the sub-module and the top.
package mux_scan_pkg;

    localparam int NCH   = 4;
    localparam int SEL_W = 2;

    // 2'd3 is unused; the FSM treats it as illegal and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [SEL_W-1:0] sel_t;
    typedef logic [NCH-1:0]   word_t;

endpackage

// File: rtl/mux_scan_controller_if.sv
// Bundle of the scan controller's handshake and mux-facing signals.
// Ports: start_i/cont_i request scans, y_i is the mux output, c_o the mux select,
//        busy_o/done_o report progress and q_o carries the captured word.
interface mux_scan_if;
    import mux_scan_pkg::*;

    logic  start_i;
    logic  cont_i;
    logic  y_i;
    sel_t  c_o;
    logic  busy_o;
    logic  done_o;
    word_t q_o;

    // master: the environment (requester plus the mux itself)
    modport master (output start_i, cont_i, y_i, input c_o, busy_o, done_o, q_o);
    // slave: the scan controller
    modport slave  (input start_i, cont_i, y_i, output c_o, busy_o, done_o, q_o);

endinterface

// File: rtl/mux_scan_controller_dwell_counter.sv
// Dwell counter: counts cycles spent on the current channel.
// Ports: clk_i/rst_i, clear_i forces zero (wins over enable_i), enable_i advances,
//        limit_i is the last count value, tc_o flags cnt == limit_i.
module dwell_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == limit_i);

endmodule

// File: rtl/mux_scan_controller.sv
// Scan sequencer: walks the 4:1 mux select through channels 0..3, DWELL cycles each,
// samples Y at the end of each dwell and publishes the 4 bits on Q with a DONE strobe.
// Ports: clk_i, rst_i (async, active-high), scan_if (slave modport of mux_scan_if).
module mux_scan_controller
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    mux_scan_if.slave  scan_if
);

    state_t           state_q;
    sel_t             c_q;
    sel_t             c_d;
    // Only channels 0..2 need holding: channel 3 is sampled in the same edge
    // that loads Q, so its bit goes straight from Y into Q.
    logic [NCH-2:0]   shadow_q;
    word_t            q_q;
    logic             scanning;
    logic             tc;

    assign scanning = (state_q == SCAN);
    assign c_d      = c_q + sel_t'(1);

    // The counter sits at zero outside SCAN and restarts at every channel
    // boundary, so entry into SCAN always begins a fresh dwell.
    dwell_counter #(
        .CNT_W (CNT_W)
    ) u_dwell (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (!scanning || tc),
        .enable_i (scanning),
        .limit_i  (CNT_W'(DWELL - 1)),
        .tc_o     (tc)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            c_q      <= '0;
            shadow_q <= '0;
            q_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    c_q <= '0;
                    if (scan_if.start_i) begin
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    // START is deliberately ignored here: no restart, no queuing.
                    if (tc) begin
                        if (c_q == sel_t'(NCH - 1)) begin
                            q_q     <= {scan_if.y_i, shadow_q};
                            c_q     <= '0;
                            state_q <= DONE;
                        end else begin
                            shadow_q[c_q] <= scan_if.y_i;
                            c_q           <= c_d;
                        end
                    end
                end
                DONE: begin
                    c_q <= '0;
                    if (scan_if.cont_i || scan_if.start_i) begin
                        state_q <= SCAN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    c_q     <= '0;
                end
            endcase
        end
    end

    assign scan_if.c_o    = c_q;
    assign scan_if.busy_o = (state_q == SCAN);
    assign scan_if.done_o = (state_q == DONE);
    assign scan_if.q_o    = q_q;

endmodule

// File: tb/tb_mux_scan_controller.sv
// Bench for mux_scan_controller: two instances (DWELL=4 and DWELL=1) driven by
// directed scenarios and random traffic, checked every cycle against a
// time-since-start model of the scan plus literal expectations.
module tb_mux_scan_controller;

    logic       clk;
    logic       rst;
    logic       start_s [2];
    logic       cont_s  [2];
    logic [3:0] x_s     [2];

    logic [1:0] c_w    [2];
    logic       busy_w [2];
    logic       done_w [2];
    logic [3:0] q_w    [2];

    int dw [2] = '{4, 1};

    mux_scan_if if0 ();
    mux_scan_if if1 ();

    assign if0.start_i = start_s[0];
    assign if0.cont_i  = cont_s[0];
    assign if0.y_i     = x_s[0][if0.c_o];
    assign if1.start_i = start_s[1];
    assign if1.cont_i  = cont_s[1];
    assign if1.y_i     = x_s[1][if1.c_o];

    assign c_w[0] = if0.c_o;   assign c_w[1] = if1.c_o;
    assign busy_w[0] = if0.busy_o; assign busy_w[1] = if1.busy_o;
    assign done_w[0] = if0.done_o; assign done_w[1] = if1.done_o;
    assign q_w[0] = if0.q_o;   assign q_w[1] = if1.q_o;

    mux_scan_controller #(.DWELL(4), .CNT_W(8)) dut0 (
        .clk_i   (clk),
        .rst_i   (rst),
        .scan_if (if0)
    );

    mux_scan_controller #(.DWELL(1), .CNT_W(8)) dut1 (
        .clk_i   (clk),
        .rst_i   (rst),
        .scan_if (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    bit chk_en = 1'b0;
    int cyc    = 0;

    task automatic check(input string name, input int d, input int act, input int exp);
        checks++;
        if (act == exp) begin
            passes++;
        end else begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s dut%0d at cycle %0d: got %0d, expected %0d", name, d, cyc, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Reference model: a scan is just "k cycles since START was taken".
    // Channel = k / DWELL; bit i is captured at k = DWELL*(i+1); DONE at k = 4*DWELL.
    bit         m_busy [2];
    bit         m_done [2];
    int         m_k    [2];
    logic [3:0] m_cap  [2];
    logic [3:0] m_q    [2];
    int         m_ch;
    bit         m_go;

    always @(posedge clk or posedge rst) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_busy[d] = 0; m_done[d] = 0; m_k[d] = 0;
                m_cap[d] = 4'b0; m_q[d] = 4'b0;
            end else if (m_busy[d]) begin
                m_k[d]++;
                if (m_k[d] % dw[d] == 0) begin
                    m_ch = m_k[d] / dw[d] - 1;
                    m_cap[d][m_ch] = x_s[d][m_ch];
                end
                if (m_k[d] == 4 * dw[d]) begin
                    m_busy[d] = 0;
                    m_done[d] = 1;
                    m_q[d]    = m_cap[d];
                end
            end else begin
                m_go = start_s[d] || (m_done[d] && cont_s[d]);
                m_done[d] = 0;
                if (m_go) begin
                    m_busy[d] = 1;
                    m_k[d]    = 0;
                end
            end
        end
    end

    // Per-cycle compare plus bookkeeping used by the literal checks.
    int         busy_cnt  [2] = '{0, 0};
    int         done_cnt  [2] = '{0, 0};
    int         last_done [2] = '{0, 0};
    int         prev_done [2] = '{0, 0};
    logic [3:0] last_q    [2];

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                check("C",    d, int'(c_w[d]),    m_busy[d] ? m_k[d] / dw[d] : 0);
                check("BUSY", d, int'(busy_w[d]), int'(m_busy[d]));
                check("DONE", d, int'(done_w[d]), int'(m_done[d]));
                check("Q",    d, int'(q_w[d]),    int'(m_q[d]));
                if (busy_w[d]) busy_cnt[d]++;
                if (done_w[d]) begin
                    done_cnt[d]++;
                    prev_done[d] = last_done[d];
                    last_done[d] = cyc;
                    last_q[d]    = q_w[d];
                end
            end
        end
    end

    task automatic pulse_start(input int d, output int e0);
        @(negedge clk);
        start_s[d] = 1'b1;
        e0 = cyc + 1;
        @(negedge clk);
        start_s[d] = 1'b0;
    endtask

    task automatic wait_done(input int d, input int budget);
        int n0 = done_cnt[d];
        int i  = 0;
        while (done_cnt[d] == n0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        check("done_seen", d, done_cnt[d] - n0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        int e0, b0, n0;
        for (int d = 0; d < 2; d++) begin
            start_s[d] = 1'b0; cont_s[d] = 1'b0; x_s[d] = 4'b0;
        end
        rst = 1'b0;

        // 1. reset asserted mid-cycle, then idle
        #3 rst = 1'b1;
        chk_en = 1'b1;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        b0 = busy_cnt[0]; n0 = done_cnt[0];
        repeat (20) @(negedge clk);
        check("idle_busy", 0, busy_cnt[0] - b0, 0);
        check("idle_done", 0, done_cnt[0] - n0, 0);

        // 2. single scan, DWELL=4, X=1010
        x_s[0] = 4'b1010;
        b0 = busy_cnt[0]; n0 = done_cnt[0];
        pulse_start(0, e0);
        repeat (20) @(negedge clk);
        check("single_busy_cycles", 0, busy_cnt[0] - b0, 16);
        check("single_done_count",  0, done_cnt[0] - n0, 1);
        check("single_done_time",   0, last_done[0] - e0, 16);
        check("single_q",           0, int'(last_q[0]), 4'b1010);

        // 4. START pulsed again at e5 is ignored
        n0 = done_cnt[0];
        pulse_start(0, e0);
        repeat (4) @(negedge clk);
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (20) @(negedge clk);
        check("restart_done_count", 0, done_cnt[0] - n0, 1);
        check("restart_done_time",  0, last_done[0] - e0, 16);

        // 3. continuous mode, X changes between scans
        cont_s[0] = 1'b1;
        x_s[0] = 4'b0110;
        pulse_start(0, e0);
        wait_done(0, 100);
        check("cont_q1",    0, int'(last_q[0]), 4'b0110);
        check("cont_time1", 0, last_done[0] - e0, 16);
        x_s[0] = 4'b1001;
        wait_done(0, 100);
        cont_s[0] = 1'b0;
        check("cont_q2",  0, int'(last_q[0]), 4'b1001);
        check("cont_gap", 0, last_done[0] - prev_done[0], 17);
        repeat (3) @(negedge clk);

        // 5. reset mid-scan
        x_s[0] = 4'b1111;
        pulse_start(0, e0);
        repeat (8) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_c",    0, int'(c_w[0]),    0);
        check("arst_busy", 0, int'(busy_w[0]), 0);
        check("arst_done", 0, int'(done_w[0]), 0);
        check("arst_q",    0, int'(q_w[0]),    0);
        n0 = done_cnt[0];
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("arst_no_done", 0, done_cnt[0] - n0, 0);
        pulse_start(0, e0);
        wait_done(0, 40);
        check("arst_fresh_q", 0, int'(last_q[0]), 4'b1111);

        // 6. DWELL=1
        x_s[1] = 4'b0011;
        pulse_start(1, e0);
        check("d1_c0", 1, int'(c_w[1]), 0);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            check("d1_c_seq", 1, int'(c_w[1]), k);
        end
        wait_done(1, 10);
        check("d1_done_time", 1, last_done[1] - e0, 4);
        check("d1_q",         1, int'(last_q[1]), 4'b0011);
        for (int v = 0; v < 16; v++) begin
            x_s[1] = 4'(v);
            pulse_start(1, e0);
            wait_done(1, 20);
            check("d1_sweep_q", 1, int'(last_q[1]), v);
        end

        // random traffic on both instances, occasional async reset
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 199) == 0);
            for (int d = 0; d < 2; d++) begin
                start_s[d] = ($urandom_range(0, 7) == 0);
                cont_s[d]  = ($urandom_range(0, 3) == 0);
                x_s[d]     = 4'($urandom);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            start_s[d] = 1'b0; cont_s[d] = 1'b0;
        end
        repeat (40) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mux_scan_controller.md
Name: mux_scan_controller

Overview:
Sequencer that drives the 2-bit select C of the 4:1 multiplexer_dataflow stage and samples its output Y.
- On START it walks C through channels 0..3, holding each for DWELL cycles so the mux output settles.
- It samples Y at the end of each dwell and presents the 4 captured bits as one parallel word Q, with a one-cycle DONE strobe.
- It sits around the mux: upstream of it on C, downstream of it on Y.

Parameters:
- DWELL, 4, clock cycles per channel (settle plus sample); legal range 1..255.
- NCH, 4, number of mux channels; fixed at 4 for this build.
- CNT_W, 8, width of the dwell counter; must hold DWELL-1.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- START  in  1  level, sampled each edge; requests one scan.
- CONT  in  1  continuous mode; when 1, a new scan starts automatically after DONE.
- C  out  2  mux select, registered.
- Y  in  1  mux output, from the multiplexer stage.
- BUSY  out  1  high while a scan is in progress.
- DONE  out  1  one-cycle pulse; Q is updated in the same cycle.
- Q  out  4  captured word; Q[i] = Y sampled while C == i.

Behaviour:
- One clock domain (CLK). RST is asynchronous and active-high.
- Reset value of every output:
  - C = 0, BUSY = 0, DONE = 0, Q = 4'b0000.
  - Internally: state = IDLE, cnt = 0, shadow = 0.
- States: IDLE, SCAN, DONE. Encoding is in the package; outputs are decoded from registered state.
  - BUSY = (state == SCAN).
  - DONE = (state == DONE).
- IDLE:
  - START = 1 at an edge → SCAN, C <= 0, cnt <= 0.
  - Otherwise stay; C holds 0.
- SCAN, at each edge:
  - If cnt != DWELL-1: cnt <= cnt+1.
  - If cnt == DWELL-1: shadow[C] <= Y.
    - If C == 3: Q <= {Y, shadow[2:0]}, C <= 0, → DONE.
    - Else: C <= C+1, cnt <= 0.
  - START is ignored in SCAN; no restart and no queuing.
- DONE, one cycle, at the next edge:
  - If CONT = 1 or START = 1 → SCAN, C <= 0, cnt <= 0, shadow kept.
  - Else → IDLE.
- Latency: START sampled at edge e0.
  - Channel i is sampled at edge e(DWELL*(i+1)).
  - DONE and the new Q are visible in the cycle after edge e(4*DWELL).
  - In continuous mode a scan repeats every 4*DWELL+1 cycles.
- Q holds its value between DONE pulses. Partial scans never alter Q.
- DWELL = 1: C advances every cycle and Y is sampled on every SCAN edge. No stall cycles.
- Y is treated as synchronous and settled by the sample edge; there is no extra synchroniser.
- Reset mid-scan: immediate abort.
  - All state and outputs return to reset values, including Q.
  - No DONE pulse is emitted.
- START and CONT both high in DONE: a single restart, same as either alone.
- Counter wrap: cnt never exceeds DWELL-1. C wraps 3 → 0 only via the DONE transition.

Decomposition:
- Package mux_scan_pkg holds:
  - State encoding constants: IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2; 2'd3 is illegal and recovers to IDLE.
  - NCH = 4.
  - Select width of 2.
- One natural sub-module: dwell_counter.
  - Parameter: CNT_W.
  - Inputs: clear, enable, limit.
  - Output: terminal-count flag tc = (cnt == limit).
  - The FSM, C register, shadow and Q stay in the top module.

Test Plan:
1. Reset then idle: assert RST mid-cycle, release, hold START = 0 for 20 cycles → C = 0, BUSY = 0, DONE = 0, Q = 0 throughout.
2. Single scan, DWELL = 4, mux fed X = 4'b1010, START pulsed at e0:
   - C = 0,1,2,3 each for 4 cycles.
   - BUSY high for 16 cycles.
   - DONE high exactly once, the cycle after e16, with Q = 4'b1010.
   - Then IDLE.
3. Continuous mode: CONT = 1, X changes from 4'b0110 to 4'b1001 between scans → consecutive DONE pulses 17 cycles apart, Q = 4'b0110 then 4'b1001.
4. START during scan: pulse START again at e5 → ignored; exactly one DONE at the cycle after e16.
5. Reset mid-scan: RST asserted at e9 of a scan with X = 4'b1111 → outputs zero immediately, no DONE, Q = 0. A fresh scan after release gives Q = 4'b1111.
6. DWELL = 1, X = 4'b0011:
   - C = 0,1,2,3 on consecutive cycles.
   - DONE the cycle after e4, with Q = 4'b0011.
   - Sweep all 16 X values and compare Q with X on every scan.
